// File: rtl/alu_iter_pkg.sv
// Shared types for the iterative execute-stage ALU: op codes, FSM states and
// the op classifier used by both the top and the mul/div engine.
package alu_iter_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SRL   = 4'd5,
        SRA   = 4'd6,
        SLL   = 4'd7,
        SLT   = 4'd8,
        SLTU  = 4'd9,
        MUL   = 4'd10,
        MULHU = 4'd11,
        DIV   = 4'd12,
        DIVU  = 4'd13,
        REM   = 4'd14,
        REMU  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply/divide ops occupy the upper block of the encoding.
    function automatic logic is_iter(input alu_op_t op);
        return (op >= MUL);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per
// cycle on a shared 2*WIDTH accumulator, with sign fix applied on the last step.
module alu_iter_muldiv
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             start_i,
    input  alu_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, step_s;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    alu_op_t            op_q, op_d;
    logic               neg_q, neg_d, run_q, run_d;
    logic               signed_s, is_mul_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s;
    logic [WIDTH:0]     sum_s, trial_s;

    assign signed_s = (op_i == DIV) || (op_i == REM);
    assign mag_a_s  = (signed_s && a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b_s  = (signed_s && b_i[WIDTH-1]) ? -b_i : b_i;
    assign is_mul_s = (op_q == MUL) || (op_q == MULHU);

    // Multiplier sits in the low half; divisor/multiplicand is held in dvs_q.
    assign sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
    assign trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};

    // One iteration of the selected algorithm.
    always_comb begin
        if (is_mul_s) begin
            step_s = {sum_s, acc_q[WIDTH-1:1]};
        end else if (trial_s[WIDTH]) begin
            step_s = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            step_s = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    assign quo_s  = step_s[WIDTH-1:0];
    assign rem_s  = step_s[2*WIDTH-1:WIDTH];
    assign done_o = run_q && (cnt_q == LAST_STEP);

    // Result selection and sign fix; a zero divisor leaves the magnitude all-ones/|a|.
    always_comb begin
        result_o = '0;
        case (op_q)
            MUL:     result_o = quo_s;
            MULHU:   result_o = rem_s;
            DIV:     result_o = (dvs_q == '0) ? '1 : (neg_q ? -quo_s : quo_s);
            DIVU:    result_o = quo_s;
            REM:     result_o = neg_q ? -rem_s : rem_s;
            REMU:    result_o = rem_s;
            default: result_o = '0;
        endcase
    end

    // Load on start, step while running, abort on flush.
    always_comb begin
        acc_d = acc_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        neg_d = neg_q;
        run_d = run_q;
        if (flush_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            acc_d = {{WIDTH{1'b0}}, mag_a_s};
            dvs_d = mag_b_s;
            cnt_d = '0;
            op_d  = op_i;
            neg_d = (op_i == DIV) ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) : ((op_i == REM) && a_i[WIDTH-1]);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = step_s;
            if (cnt_q == LAST_STEP) begin
                cnt_d = '0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            op_q  <= ADD;
            neg_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
            neg_q <= neg_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready handshakes, single-cycle datapath and an
// iterative mul/div engine. Define ALU_ITER_FLAGS_EN to add the {N,Z,C,V} flags port.
module alu_iter_exec
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef ALU_ITER_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d, alu_s, md_result_s;
    logic               out_valid_q, out_valid_d, busy_q, busy_d;
    logic               in_ready_s, accept_s, start_s, md_done_s;
    alu_op_t            op_s;
    logic [SHAMT_W-1:0] shamt_s;

    assign op_s       = alu_op_t'(op);
    assign shamt_s    = b[SHAMT_W-1:0];
    assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Single-cycle datapath; iterative and unused codes yield zero here.
    always_comb begin
        alu_s = '0;
        case (op_s)
            ADD:     alu_s = a + b;
            SUB:     alu_s = a - b;
            AND:     alu_s = a & b;
            OR:      alu_s = a | b;
            XOR:     alu_s = a ^ b;
            SRL:     alu_s = a >> shamt_s;
            SRA:     alu_s = $signed(a) >>> shamt_s;
            SLL:     alu_s = a << shamt_s;
            SLT:     alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:    alu_s = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_s = '0;
        endcase
    end

`ifdef ALU_ITER_FLAGS_EN
    logic [WIDTH:0] add_c_s, sub_c_s;
    logic [3:0]     flags_q, flags_d, flg_s;

    assign add_c_s = {1'b0, a} + {1'b0, b};
    assign sub_c_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign flags   = flags_q;

    // {N,Z,C,V} for ADD/SUB; SUB carry is the no-borrow indication.
    always_comb begin
        flg_s = 4'b0000;
        case (op_s)
            ADD: flg_s = {add_c_s[WIDTH-1], (add_c_s[WIDTH-1:0] == '0), add_c_s[WIDTH],
                          (a[WIDTH-1] == b[WIDTH-1]) && (add_c_s[WIDTH-1] != a[WIDTH-1])};
            SUB: flg_s = {sub_c_s[WIDTH-1], (sub_c_s[WIDTH-1:0] == '0), sub_c_s[WIDTH],
                          (a[WIDTH-1] != b[WIDTH-1]) && (sub_c_s[WIDTH-1] != a[WIDTH-1])};
            default: flg_s = 4'b0000;
        endcase
    end
`endif

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .start_i  (start_s),
        .op_i     (op_s),
        .a_i      (a),
        .b_i      (b),
        .done_o   (md_done_s),
        .result_o (md_result_s)
    );

    // FSM next state; DONE with out_ready behaves like IDLE so back-to-back ops need no bubble.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        start_s     = 1'b0;
`ifdef ALU_ITER_FLAGS_EN
        flags_d     = flags_q;
`endif
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if ((state_q == DONE) && out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                    if (accept_s) begin
                        if (is_iter(op_s)) begin
                            state_d     = BUSY;
                            busy_d      = 1'b1;
                            start_s     = 1'b1;
                            out_valid_d = 1'b0;
                        end else begin
                            state_d     = DONE;
                            result_d    = alu_s;
                            out_valid_d = 1'b1;
`ifdef ALU_ITER_FLAGS_EN
                            flags_d     = flg_s;
`endif
                        end
                    end else begin
                        start_s = 1'b0;
                    end
                end
                BUSY: begin
                    if (md_done_s) begin
                        state_d     = DONE;
                        result_d    = md_result_s;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
`ifdef ALU_ITER_FLAGS_EN
                        flags_d     = 4'b0000;
`endif
                    end else begin
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ALU_ITER_FLAGS_EN
            flags_q     <= 4'b0000;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ALU_ITER_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed corner cases, randomized
// operands against an arithmetic reference model, backpressure, flush and reset.
module tb_alu_iter_exec;
    import alu_iter_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;
`ifdef ALU_ITER_FLAGS_EN
    logic [3:0]   flags;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_iter_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef ALU_ITER_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0]       prod;
        logic signed [W-1:0]  sres;
        int unsigned          sh;
        sh   = y % 32'd32;
        prod = {32'd0, x} * {32'd0, y};
        case (o)
            ADD:   return x + y;
            SUB:   return x - y;
            AND:   return x & y;
            OR:    return x | y;
            XOR:   return x ^ y;
            SRL:   return x >> sh;
            SRA:   begin sres = $signed(x) >>> sh; return sres; end
            SLL:   return x << sh;
            SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            SLTU:  return (x < y) ? 32'd1 : 32'd0;
            MUL:   return prod[W-1:0];
            MULHU: return prod[2*W-1:W];
            DIV: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == MINV && y == 32'hFFFF_FFFF) return MINV;
                sres = $signed(x) / $signed(y);
                return sres;
            end
            DIVU:  return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            REM: begin
                if (y == 32'd0) return x;
                if (x == MINV && y == 32'hFFFF_FFFF) return 32'd0;
                sres = $signed(x) % $signed(y);
                return sres;
            end
            REMU:  return (y == 32'd0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0: return 32'd0;
            1: return MINV;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with out_ready high, wait for the result, check value, latency and busy/in_ready.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp, input string tag);
        int           cyc;
        logic         busy_ok;
        logic [W-1:0] bflag;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 100) begin
            if (!(busy === 1'b1 && in_ready === 1'b0)) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, "/res"}, result, exp);
        check({tag, "/lat"}, cyc, is_iter(alu_op_t'(o)) ? 32'd33 : 32'd1);
        bflag = {30'd0, busy_ok, busy};
        check({tag, "/busy"}, bflag, 32'd2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic         ok;
        logic [W-1:0] x, y, hold;
        logic [3:0]   o;

        #12;
        check("rst/valid", {31'd0, out_valid}, 32'd0);
        check("rst/busy",  {31'd0, busy},      32'd0);
        check("rst/res",   result,             32'd0);
        check("rst/ready", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_ovf");
`ifdef ALU_ITER_FLAGS_EN
        check("add_ovf/flags", {28'd0, flags}, 32'h9);
`endif
        run_op(SUB, 32'd5, 32'd5, 32'd0, "sub_zero");
`ifdef ALU_ITER_FLAGS_EN
        check("sub_zero/flags", {28'd0, flags}, 32'h6);
`endif
        run_op(SRA,   32'h8000_0000, 32'h24, 32'hF800_0000, "sra");
        run_op(SLL,   32'h1234_5678, 32'd32, 32'h1234_5678, "sll32");
        run_op(SLT,   32'hFFFF_FFFF, 32'd1,  32'd1,         "slt");
        run_op(SLTU,  32'hFFFF_FFFF, 32'd1,  32'd0,         "sltu");
        run_op(MUL,   32'hFFFF_FFFF, 32'd2,  32'hFFFF_FFFE, "mul");
        run_op(MULHU, 32'hFFFF_FFFF, 32'd2,  32'd1,         "mulhu");
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, "div");
        run_op(REM,   32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, "rem");
        run_op(DIVU,  32'd5,         32'd0,  32'hFFFF_FFFF, "divu0");
        run_op(REM,   32'd5,         32'd0,  32'd5,         "rem0");
        run_op(DIV,   MINV, 32'hFFFF_FFFF,   MINV,          "div_ovf");
        run_op(REM,   MINV, 32'hFFFF_FFFF,   32'd0,         "rem_ovf");

        for (int i = 0; i < 48; i++) begin
            o = 4'(i % 16);
            x = pick();
            y = pick();
            run_op(o, x, y, model(o, x, y), "rnd");
        end

        // Backpressure then back-to-back accept.
        @(negedge clk);
        op = ADD; a = 32'd10; b = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp/valid", {31'd0, out_valid}, 32'd1);
        check("bp/res", result, 32'd30);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (result !== 32'd30 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        check("bp/stable", {31'd0, ok}, 32'd1);
        op = SUB; a = 32'd100; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp/b2b_valid", {31'd0, out_valid}, 32'd1);
        check("bp/b2b_res", result, 32'd99);

        // Flush during BUSY of a DIV.
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl/busy",  {31'd0, busy},      32'd0);
        check("fl/ready", {31'd0, in_ready},  32'd1);
        ok = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        check("fl/never_valid", {31'd0, ok}, 32'd0);

        // Flush in DONE wins over a simultaneous accept.
        @(negedge clk);
        op = ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        hold = result;
        check("fl2/pre_res", hold, 32'd7);
        op = ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("fl2/valid", {31'd0, out_valid}, 32'd0);
        check("fl2/ready", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        check("fl2/still_idle", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-MUL.
        @(negedge clk);
        op = MUL; a = 32'd12345; b = 32'd678; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst2/busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2/valid", {31'd0, out_valid}, 32'd0);
        check("rst2/busy",  {31'd0, busy},      32'd0);
        check("rst2/res",   result,             32'd0);
        check("rst2/ready", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        check("rst2/no_partial", {31'd0, ok}, 32'd0);
        run_op(MUL, 32'd12345, 32'd678, 32'd8369910, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
